// File: rtl/ahbl_decmux.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_decmux
// Purpose  : AHB-Lite 1-to-N slave interconnect. Decodes the top four address
//            bits into a one-hot slave select. Tracks the owner of the data
//            phase in a registered select. Muxes read data and responses from
//            that owner back to the master. A built-in default slave answers
//            unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            ahbl_*  (master)    - address/control/wdata in; hrdata/hready/hresp out
//            s_hsel, s_h*        - per-slave select plus broadcast address/control/wdata
//            s_hreadyin          - copy of ahbl_hready for every slave
//            s_hrdata/hready/hresp - per-slave data-phase returns
// Revision : 1.0 - initial release
// ============================================================================
module ahbl_decmux #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_WIDTH-1:0]              ahbl_haddr,
  input  logic [2:0]                         ahbl_hburst,
  input  logic                               ahbl_hmastlock,
  input  logic [3:0]                         ahbl_hprot,
  input  logic [2:0]                         ahbl_hsize,
  input  logic [1:0]                         ahbl_htrans,
  input  logic [DATA_WIDTH-1:0]              ahbl_hwdata,
  input  logic                               ahbl_hwrite,
  output logic [DATA_WIDTH-1:0]              ahbl_hrdata,
  output logic                               ahbl_hready,
  output logic                               ahbl_hresp,
  output logic [NUM_SLAVES-1:0]              s_hsel,
  output logic [NUM_SLAVES*(ADDR_WIDTH-4)-1:0] s_haddr,
  output logic [NUM_SLAVES*3-1:0]            s_hburst,
  output logic [NUM_SLAVES-1:0]              s_hmastlock,
  output logic [NUM_SLAVES*4-1:0]            s_hprot,
  output logic [NUM_SLAVES*3-1:0]            s_hsize,
  output logic [NUM_SLAVES*2-1:0]            s_htrans,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_hwdata,
  output logic [NUM_SLAVES-1:0]              s_hwrite,
  output logic [NUM_SLAVES-1:0]              s_hreadyin,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_hrdata,
  input  logic [NUM_SLAVES-1:0]              s_hready,
  input  logic [NUM_SLAVES-1:0]              s_hresp
);

  localparam int         SLV_AW  = ADDR_WIDTH - 4;
  localparam logic [4:0] NS_LIM  = 5'(NUM_SLAVES);

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  logic [3:0] region;
  logic       mapped;
  logic       dflt_capture;

  logic [3:0] dsel;
  logic       dact;
  logic [1:0] ds_state;
  logic [1:0] ds_next;
  logic       ds_hready;
  logic       ds_hresp;

  logic [DATA_WIDTH-1:0] sl_rdata;
  logic                  sl_ready;
  logic                  sl_resp;

  assign region = ahbl_haddr[ADDR_WIDTH-1 -: 4];
  // Widen by one bit so NUM_SLAVES = 16 compares correctly.
  assign mapped = ({1'b0, region} < NS_LIM);
  // An unmapped active transfer is accepted by the default slave on this edge.
  assign dflt_capture = ahbl_hready & ~mapped & ahbl_htrans[1];

  // Per-slave select and broadcast of the address-phase signals.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
    assign s_hsel[i]                        = ~rst & (region == 4'(i));
    assign s_haddr[i*SLV_AW +: SLV_AW]      = ahbl_haddr[SLV_AW-1:0];
    assign s_hburst[i*3 +: 3]               = ahbl_hburst;
    assign s_hmastlock[i]                   = ahbl_hmastlock;
    assign s_hprot[i*4 +: 4]                = ahbl_hprot;
    assign s_hsize[i*3 +: 3]                = ahbl_hsize;
    assign s_htrans[i*2 +: 2]               = ahbl_htrans;
    assign s_hwdata[i*DATA_WIDTH +: DATA_WIDTH] = ahbl_hwdata;
    assign s_hwrite[i]                      = ahbl_hwrite;
    assign s_hreadyin[i]                    = ahbl_hready;
  end

  // Data-phase owner, captured only when the current transfer completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dsel <= 4'd0;
      dact <= 1'b0;
    end else if (ahbl_hready) begin
      dsel <= region;
      dact <= mapped;
    end
  end

  // Default-slave FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ds_state <= DS_IDLE;
    end else begin
      ds_state <= ds_next;
    end
  end

  // Default-slave FSM: next state.
  always_comb begin
    ds_next = DS_IDLE;
    case (ds_state)
      DS_IDLE: ds_next = dflt_capture ? DS_ERR1 : DS_IDLE;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = dflt_capture ? DS_ERR1 : DS_IDLE;
      default: ds_next = DS_IDLE;
    endcase
  end

  // Default-slave FSM: outputs (two-cycle ERROR response).
  always_comb begin
    ds_hready = 1'b1;
    ds_hresp  = 1'b0;
    case (ds_state)
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = 1'b1;
      end
      DS_ERR2: begin
        ds_hready = 1'b1;
        ds_hresp  = 1'b1;
      end
      default: begin
        ds_hready = 1'b1;
        ds_hresp  = 1'b0;
      end
    endcase
  end

  // Return-path mux, written as a loop so an out-of-range dsel selects nothing.
  always_comb begin
    sl_rdata = '0;
    sl_ready = 1'b1;
    sl_resp  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel == 4'(i)) begin
        sl_rdata = s_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
        sl_ready = s_hready[i];
        sl_resp  = s_hresp[i];
      end
    end
  end

  assign ahbl_hrdata = dact ? sl_rdata : '0;
  assign ahbl_hready = dact ? sl_ready : ds_hready;
  assign ahbl_hresp  = dact ? sl_resp  : ds_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_decmux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahbl_decmux
// Purpose  : Self-checking bench for ahbl_decmux with NUM_SLAVES = 3. The bench
//            plays the slaves. A transaction-level model predicts the outputs:
//            it holds the owner of the pending data phase, which is none, a
//            slave index, or the default slave in error phase 1 or 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahbl_decmux;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 3;
  localparam int SAW = AW - 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    ahbl_haddr;
  logic [2:0]       ahbl_hburst;
  logic             ahbl_hmastlock;
  logic [3:0]       ahbl_hprot;
  logic [2:0]       ahbl_hsize;
  logic [1:0]       ahbl_htrans;
  logic [DW-1:0]    ahbl_hwdata;
  logic             ahbl_hwrite;
  logic [DW-1:0]    ahbl_hrdata;
  logic             ahbl_hready;
  logic             ahbl_hresp;
  logic [NS-1:0]    s_hsel;
  logic [NS*SAW-1:0] s_haddr;
  logic [NS*3-1:0]  s_hburst;
  logic [NS-1:0]    s_hmastlock;
  logic [NS*4-1:0]  s_hprot;
  logic [NS*3-1:0]  s_hsize;
  logic [NS*2-1:0]  s_htrans;
  logic [NS*DW-1:0] s_hwdata;
  logic [NS-1:0]    s_hwrite;
  logic [NS-1:0]    s_hreadyin;
  logic [NS*DW-1:0] s_hrdata;
  logic [NS-1:0]    s_hready;
  logic [NS-1:0]    s_hresp;

  always #5 clk = ~clk;

  ahbl_decmux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) dut (
    .clk(clk), .rst(rst),
    .ahbl_haddr(ahbl_haddr), .ahbl_hburst(ahbl_hburst), .ahbl_hmastlock(ahbl_hmastlock),
    .ahbl_hprot(ahbl_hprot), .ahbl_hsize(ahbl_hsize), .ahbl_htrans(ahbl_htrans),
    .ahbl_hwdata(ahbl_hwdata), .ahbl_hwrite(ahbl_hwrite),
    .ahbl_hrdata(ahbl_hrdata), .ahbl_hready(ahbl_hready), .ahbl_hresp(ahbl_hresp),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_hburst(s_hburst), .s_hmastlock(s_hmastlock),
    .s_hprot(s_hprot), .s_hsize(s_hsize), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
    .s_hwrite(s_hwrite), .s_hreadyin(s_hreadyin),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  int tests = 0;
  int fails = 0;

  // Model: m_owner = -1 none, 0..NS-1 slave, NS default slave (m_phase 1 or 2).
  int m_owner = -1;
  int m_phase = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [AW-1:0] a, input logic [1:0] t, input logic w);
    ahbl_haddr     = a;
    ahbl_htrans    = t;
    ahbl_hwrite    = w;
    ahbl_hburst    = 3'($urandom_range(0, 7));
    ahbl_hmastlock = 1'($urandom_range(0, 1));
    ahbl_hprot     = 4'($urandom_range(0, 15));
    ahbl_hsize     = 3'($urandom_range(0, 2));
    ahbl_hwdata    = $urandom;
    for (int k = 0; k < NS; k++) s_hrdata[k*DW +: DW] = $urandom;
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic step();
    logic [NS-1:0]     e_sel;
    logic [NS*SAW-1:0] e_haddr;
    logic [NS*DW-1:0]  e_wdata;
    logic [NS*2-1:0]   e_trans;
    logic [NS*3-1:0]   e_burst;
    logic [DW-1:0]     e_rdata;
    logic              e_rdy;
    logic              e_resp;
    int                reg_n;
    logic              t_act;
    logic              r_now;
    #1;
    reg_n = int'(ahbl_haddr >> 28);
    t_act = ahbl_htrans[1];
    r_now = rst;
    e_sel = '0;
    if (!rst && reg_n < NS) e_sel[reg_n] = 1'b1;
    for (int k = 0; k < NS; k++) begin
      e_haddr[k*SAW +: SAW] = ahbl_haddr[SAW-1:0];
      e_wdata[k*DW +: DW]   = ahbl_hwdata;
      e_trans[k*2 +: 2]     = ahbl_htrans;
      e_burst[k*3 +: 3]     = ahbl_hburst;
    end
    if (m_owner < 0) begin
      e_rdata = '0; e_rdy = 1'b1; e_resp = 1'b0;
    end else if (m_owner == NS) begin
      e_rdata = '0; e_rdy = (m_phase == 2); e_resp = 1'b1;
    end else begin
      e_rdata = s_hrdata[m_owner*DW +: DW];
      e_rdy   = s_hready[m_owner];
      e_resp  = s_hresp[m_owner];
    end
    chk("hsel",     128'(s_hsel),      128'(e_sel));
    chk("haddr",    128'(s_haddr),     128'(e_haddr));
    chk("hwdata",   128'(s_hwdata),    128'(e_wdata));
    chk("htrans",   128'(s_htrans),    128'(e_trans));
    chk("hburst",   128'(s_hburst),    128'(e_burst));
    chk("hwrite",   128'(s_hwrite),    128'({NS{ahbl_hwrite}}));
    chk("hrdata",   128'(ahbl_hrdata), 128'(e_rdata));
    chk("hready",   128'(ahbl_hready), 128'(e_rdy));
    chk("hresp",    128'(ahbl_hresp),  128'(e_resp));
    chk("hreadyin", 128'(s_hreadyin),  128'({NS{e_rdy}}));
    @(posedge clk);
    if (r_now) begin
      m_owner = -1;
    end else if (m_owner == NS && m_phase == 1) begin
      m_phase = 2;
    end else if (e_rdy) begin
      if (reg_n < NS)  m_owner = reg_n;
      else if (t_act) begin m_owner = NS; m_phase = 1; end
      else             m_owner = -1;
    end
    #1;
  endtask

  int lows;

  initial begin
    rst = 1'b1;
    s_hready = '1;
    s_hresp  = '0;
    set_req(32'h0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    // Reset held: outputs idle and select forced off even for a mapped address.
    set_req(32'h1000_0000, 2'b10, 1'b0);
    step();
    rst = 1'b0;

    // Mapped read to slave 1, then its data phase.
    set_req(32'h1000_0040, 2'b10, 1'b0);
    step();
    set_req(32'h0, 2'b00, 1'b0);
    s_hrdata[1*DW +: DW] = 32'hDEAD_BEEF;
    step();

    // Unmapped NONSEQ write: ERR1, ERR2, then OKAY.
    set_req(32'h5000_0000, 2'b10, 1'b1);
    step();
    set_req(32'h0, 2'b00, 1'b0);
    step();
    step();
    step();

    // Slave 0 stalls three cycles while slave 2's address is presented.
    set_req(32'h0000_0000, 2'b10, 1'b0);
    step();
    set_req(32'h2000_0004, 2'b10, 1'b0);
    s_hready[0] = 1'b0;
    lows = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (!ahbl_hready) lows++;
      step();
    end
    s_hready[0] = 1'b1;
    #1;
    if (!ahbl_hready) lows++;
    step();
    chk("stall_cycles", 128'(lows), 128'(3));
    set_req(32'h0, 2'b00, 1'b0);
    step();

    // IDLE to an unmapped region: zero-wait OKAY.
    set_req(32'h7000_0000, 2'b00, 1'b0);
    step();
    step();

    // Back-to-back unmapped NONSEQs.
    set_req(32'h4000_0000, 2'b10, 1'b0);
    step();
    set_req(32'h0, 2'b00, 1'b0);
    step();
    set_req(32'h6000_0000, 2'b10, 1'b0);
    step();
    set_req(32'h0, 2'b00, 1'b0);
    step();
    step();
    step();

    // Reset during ERR1.
    set_req(32'h9000_0000, 2'b10, 1'b0);
    step();
    rst = 1'b1;
    set_req(32'h1000_0000, 2'b10, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Reset during a slave wait state.
    set_req(32'h1000_0000, 2'b10, 1'b0);
    step();
    s_hready[1] = 1'b0;
    set_req(32'h0000_0008, 2'b10, 1'b0);
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    s_hready = '1;

    // Randomised traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_req({4'($urandom_range(0, 5)), 28'($urandom)}, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
      for (int k = 0; k < NS; k++) begin
        s_hready[k] = ($urandom_range(0, 3) != 0);
        s_hresp[k]  = ($urandom_range(0, 7) == 0);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
